// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared types and constants for the MIPS fetch/data bus arbiter.
//   DATA_W      : width of every data path (32)
//   BE_FULL     : byte enable used for instruction fetches (4'b1111)
//   arb_state_t : arbiter FSM state (IDLE, GRANT_I, GRANT_D); the encodings
//                 are also exported as plain localparams for older code that
//                 compares raw state bits.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mips_bus_pkg;

  localparam int DATA_W = 32;
  localparam logic [3:0] BE_FULL = 4'b1111;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    GRANT_I = S_GRANT_I,
    GRANT_D = S_GRANT_D
  } arb_state_t;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter_if
// Bundles the three buses around the arbiter: the instruction-fetch port,
// the data port and the shared memory bus, plus the sticky bus_error flag.
//   modport slave  : the arbiter's view (fetch/data requests in, memory
//                    strobes out, memory response in, bus_error out)
//   modport master : the environment's view (CPUs and memory), mirror image
// Parameter ADDR_W sets the width of all address signals.
// -----------------------------------------------------------------------------
interface mips_bus_arbiter_if
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32
);

  // Instruction-fetch port
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;

  // Data port
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [3:0]        d_byteenable;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;

  // Shared memory bus
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  logic              bus_error;

  modport slave (
    input  i_read, i_address,
    output i_waitrequest, i_readdata,
    input  d_read, d_write, d_address, d_writedata, d_byteenable,
    output d_waitrequest, d_readdata,
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata,
    output bus_error
  );

  modport master (
    output i_read, i_address,
    input  i_waitrequest, i_readdata,
    output d_read, d_write, d_address, d_writedata, d_byteenable,
    input  d_waitrequest, d_readdata,
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata,
    input  bus_error
  );

endinterface

// File: rtl/mips_arb_pick.sv
// -----------------------------------------------------------------------------
// mips_arb_pick
// Combinational grant decision between the fetch and data ports.
//   prefer_d   : in  round-robin pointer, 1 = data port wins a tie
//                    (present only when MIPS_ARB_ROUND_ROBIN_EN is defined)
//   fetch_req  : in  fetch port is requesting
//   data_req   : in  data port is requesting
//   grant_i    : out fetch port selected
//   grant_d    : out data port selected
// Build option MIPS_ARB_ROUND_ROBIN_EN: ties go to the port not served last;
// without it the data port always wins a tie.
// -----------------------------------------------------------------------------
module mips_arb_pick (
`ifdef MIPS_ARB_ROUND_ROBIN_EN
  input  logic prefer_d,
`endif
  input  logic fetch_req,
  input  logic data_req,
  output logic grant_i,
  output logic grant_d
);

  always_comb begin
    grant_d = data_req;
    grant_i = fetch_req & ~data_req;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    if (fetch_req && data_req) begin
      grant_d = prefer_d;
      grant_i = ~prefer_d;
    end
`endif
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared
// memory bus with a waitrequest handshake and a transfer timeout.
//   clk    : in  single clock, rising edge
//   reset  : in  asynchronous, active-low reset
//   bus    : mips_bus_arbiter_if.slave (fetch port, data port, memory bus,
//            sticky bus_error)
// Parameters:
//   ADDR_W   : address width (must match the interface instance)
//   MAX_WAIT : waitrequest-high cycles tolerated before a transfer is
//              aborted, legal range 2..255
// Build option MIPS_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of
// fixed data-first priority.
//
// A grant is registered in IDLE and the bus strobes come up the cycle after.
// Address, write data and byte enables are captured at grant so the bus stays
// stable even if a master misbehaves mid-transfer. Every transfer returns to
// IDLE, so at least one idle cycle separates consecutive grants.
// -----------------------------------------------------------------------------
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  mips_bus_arbiter_if.slave bus
);

  arb_state_t        state_reg, state_next;
  logic [7:0]        wait_cnt_reg;
  logic              bus_error_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [3:0]        be_reg;

  logic fetch_req, data_req;
  logic pick_fetch, pick_data;
  logic granted, timeout, done_ok, complete, start;

  assign fetch_req = bus.i_read;
  assign data_req  = bus.d_read | bus.d_write;

  assign granted  = (state_reg != IDLE);
  // The timeout cycle is itself the forced completion: strobes are already
  // down and the granted port sees waitrequest low with zero data.
  assign timeout  = granted && (wait_cnt_reg == 8'(MAX_WAIT));
  assign done_ok  = granted && !timeout && !bus.waitrequest;
  assign complete = done_ok || timeout;
  assign start    = (state_reg == IDLE) && (pick_fetch || pick_data);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  logic prefer_d_reg;

  // Points at the port that should win the next tie; flips to the other
  // port every time a transfer finishes (normally or by timeout).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prefer_d_reg <= 1'b1;
    end else if (complete) begin
      prefer_d_reg <= (state_reg == GRANT_I);
    end
  end
`endif

  mips_arb_pick u_pick (
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    .prefer_d  (prefer_d_reg),
`endif
    .fetch_req (fetch_req),
    .data_req  (data_req),
    .grant_i   (pick_fetch),
    .grant_d   (pick_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_data) begin
          state_next = GRANT_D;
        end else if (pick_fetch) begin
          state_next = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (complete) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 8'd0;
      bus_error_reg <= 1'b0;
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      be_reg        <= 4'd0;
    end else begin
      state_reg <= state_next;

      if (start) begin
        wait_cnt_reg <= 8'd0;
        addr_reg     <= pick_data ? bus.d_address : bus.i_address;
        write_reg    <= pick_data & bus.d_write;
        wdata_reg    <= pick_data ? bus.d_writedata : '0;
        be_reg       <= pick_data ? bus.d_byteenable : BE_FULL;
      end else if (granted && bus.waitrequest && !timeout) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      if (timeout) begin
        bus_error_reg <= 1'b1;
      end
    end
  end

  assign bus.address    = granted ? addr_reg : '0;
  assign bus.read       = granted && !timeout && !write_reg;
  assign bus.write      = granted && !timeout && write_reg;
  assign bus.writedata  = granted ? wdata_reg : '0;
  assign bus.byteenable = granted ? be_reg : 4'd0;

  // A waiting port is stalled until it is served; the reset term forces both
  // stalls low while reset is held, independent of the clock.
  assign bus.i_waitrequest = reset && ((state_reg == GRANT_I) ? !complete : fetch_req);
  assign bus.d_waitrequest = reset && ((state_reg == GRANT_D) ? !complete : data_req);

  assign bus.i_readdata = ((state_reg == GRANT_I) && done_ok) ? bus.readdata : '0;
  assign bus.d_readdata = ((state_reg == GRANT_D) && done_ok) ? bus.readdata : '0;

  assign bus.bus_error = bus_error_reg;

endmodule
